// File: rtl/vip_filter_frame_ctrl.sv
// Frame-level controller behind the 3x3 median filter: per-frame stream select, mode commit in vblank,
// border masking and line/frame geometry measurement against the configured image size.
module vip_filter_frame_ctrl #(
  parameter int         IMG_W    = 640,
  parameter int         IMG_H    = 480,
  parameter int         CNT_W    = 12,
  parameter logic [1:0] DEF_MODE = 2'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [1:0]       cfg_mode,
  input  logic             pe_frame_vsync,
  input  logic             pe_frame_href,
  input  logic             pe_frame_clken,
  input  logic [7:0]       pe_img_Y,
  input  logic             mf_frame_vsync,
  input  logic             mf_frame_href,
  input  logic             mf_frame_clken,
  input  logic [7:0]       mf_img_Y,
  output logic             pos_frame_vsync,
  output logic             pos_frame_href,
  output logic             pos_frame_clken,
  output logic [7:0]       pos_img_Y,
  output logic [1:0]       active_mode,
  output logic             cfg_pending,
  output logic             frame_done,
  output logic             line_err,
  output logic             frame_err,
  output logic [CNT_W-1:0] meas_width,
  output logic [CNT_W-1:0] meas_height
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GAP   = 2'd1;
  localparam logic [1:0] S_FRAME = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] W_EXP    = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] H_EXP    = CNT_W'(IMG_H);
  localparam logic [CNT_W-1:0] W_LAST   = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(IMG_H - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       pendMode_q, pendMode_d;
  logic             pend_q, pend_d;
  logic             vsPrev_q, hrPrev_q;
  logic [CNT_W-1:0] colCnt_q, colCnt_d;
  logic [CNT_W-1:0] rowCnt_q, rowCnt_d;
  logic             errAcc_q, errAcc_d;
  logic             frameDone_q, frameDone_d;
  logic             lineErr_q, lineErr_d;
  logic             frameErr_q, frameErr_d;
  logic [CNT_W-1:0] measW_q, measW_d;
  logic [CNT_W-1:0] measH_q, measH_d;
  logic             posVs_q, posVs_d;
  logic             posHr_q, posHr_d;
  logic             posCk_q, posCk_d;
  logic [7:0]       posY_q, posY_d;

  logic selVs, selHr, selCk;
  logic vsRise, vsFall, hrFall;
  logic lineBad, borderPix, commitOk, outEn;
  logic [7:0] modeY;

  // Mode 0 runs on the unfiltered stream; every other mode follows the median-filter timing.
  always_comb begin
    selVs = (mode_q == 2'd0) ? pe_frame_vsync : mf_frame_vsync;
    selHr = (mode_q == 2'd0) ? pe_frame_href  : mf_frame_href;
    selCk = (mode_q == 2'd0) ? pe_frame_clken : mf_frame_clken;
  end

  assign vsRise    = selVs & ~vsPrev_q;
  assign vsFall    = ~selVs & vsPrev_q;
  assign hrFall    = ~selHr & hrPrev_q;
  assign lineBad   = (colCnt_q != W_EXP);
  assign borderPix = (colCnt_q == '0) || (colCnt_q == W_LAST) ||
                     (rowCnt_q == '0) || (rowCnt_q == H_LAST);
  // Both streams must be in vblank so that a stream switch cannot split a frame.
  assign commitOk  = (state_q == S_GAP) && !pe_frame_vsync && !mf_frame_vsync &&
                     (pend_q || cfg_valid);
  assign outEn     = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    colCnt_d    = colCnt_q;
    rowCnt_d    = rowCnt_q;
    errAcc_d    = errAcc_q;
    frameDone_d = 1'b0;
    lineErr_d   = 1'b0;
    frameErr_d  = frameErr_q;
    measW_d     = measW_q;
    measH_d     = measH_q;
    case (state_q)
      S_IDLE: begin
        if (!selVs) state_d = S_GAP;
      end
      S_GAP: begin
        if (vsRise) begin
          state_d  = S_FRAME;
          colCnt_d = '0;
          rowCnt_d = '0;
          errAcc_d = 1'b0;
        end
      end
      S_FRAME: begin
        if (selHr && selCk && (colCnt_q != CNT_MAX)) colCnt_d = colCnt_q + CNT_W'(1);
        if (hrFall) begin
          measW_d   = colCnt_q;
          lineErr_d = lineBad;
          colCnt_d  = '0;
          if (rowCnt_q != CNT_MAX) rowCnt_d = rowCnt_q + CNT_W'(1);
          if (lineBad) errAcc_d = 1'b1;
        end
        if (vsFall) begin
          state_d     = S_GAP;
          frameDone_d = 1'b1;
          measH_d     = rowCnt_q;
          frameErr_d  = (rowCnt_q != H_EXP) | errAcc_q | (hrFall & lineBad);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A later request simply overwrites the pending one; a request in the commit cycle wins directly.
  always_comb begin
    mode_d     = mode_q;
    pendMode_d = pendMode_q;
    pend_d     = pend_q;
    if (commitOk) begin
      mode_d = cfg_valid ? cfg_mode : pendMode_q;
      pend_d = 1'b0;
    end else if (cfg_valid) begin
      pendMode_d = cfg_mode;
      pend_d     = 1'b1;
    end
  end

  always_comb begin
    case (mode_q)
      2'd0:    modeY = pe_img_Y;
      2'd1:    modeY = mf_img_Y;
      2'd2:    modeY = borderPix ? 8'h00 : mf_img_Y;
      default: modeY = 8'h00;
    endcase
    posVs_d = outEn & selVs;
    posHr_d = outEn & selHr;
    posCk_d = outEn & selCk;
    posY_d  = (outEn && selHr) ? modeY : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= DEF_MODE;
      pendMode_q  <= 2'd0;
      pend_q      <= 1'b0;
      vsPrev_q    <= 1'b0;
      hrPrev_q    <= 1'b0;
      colCnt_q    <= '0;
      rowCnt_q    <= '0;
      errAcc_q    <= 1'b0;
      frameDone_q <= 1'b0;
      lineErr_q   <= 1'b0;
      frameErr_q  <= 1'b0;
      measW_q     <= '0;
      measH_q     <= '0;
      posVs_q     <= 1'b0;
      posHr_q     <= 1'b0;
      posCk_q     <= 1'b0;
      posY_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      pendMode_q  <= pendMode_d;
      pend_q      <= pend_d;
      vsPrev_q    <= selVs;
      hrPrev_q    <= selHr;
      colCnt_q    <= colCnt_d;
      rowCnt_q    <= rowCnt_d;
      errAcc_q    <= errAcc_d;
      frameDone_q <= frameDone_d;
      lineErr_q   <= lineErr_d;
      frameErr_q  <= frameErr_d;
      measW_q     <= measW_d;
      measH_q     <= measH_d;
      posVs_q     <= posVs_d;
      posHr_q     <= posHr_d;
      posCk_q     <= posCk_d;
      posY_q      <= posY_d;
    end
  end

  assign pos_frame_vsync = posVs_q;
  assign pos_frame_href  = posHr_q;
  assign pos_frame_clken = posCk_q;
  assign pos_img_Y       = posY_q;
  assign active_mode     = mode_q;
  assign cfg_pending     = pend_q;
  assign frame_done      = frameDone_q;
  assign line_err        = lineErr_q;
  assign frame_err       = frameErr_q;
  assign meas_width      = measW_q;
  assign meas_height     = measH_q;

endmodule

// File: tb/tb_vip_filter_frame_ctrl.sv
// Scoreboard bench for vip_filter_frame_ctrl on a small 8x4 image: expected pixels are queued as
// frames are driven and popped by a monitor when the DUT emits valid output pixels.
module tb_vip_filter_frame_ctrl;

  localparam int         IMG_W    = 8;
  localparam int         IMG_H    = 4;
  localparam int         CNT_W    = 12;
  localparam logic [1:0] DEF_MODE = 2'd1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic [1:0]       cfg_mode;
  logic             pe_frame_vsync, pe_frame_href, pe_frame_clken;
  logic [7:0]       pe_img_Y;
  logic             mf_frame_vsync, mf_frame_href, mf_frame_clken;
  logic [7:0]       mf_img_Y;
  logic             pos_frame_vsync, pos_frame_href, pos_frame_clken;
  logic [7:0]       pos_img_Y;
  logic [1:0]       active_mode;
  logic             cfg_pending, frame_done, line_err, frame_err;
  logic [CNT_W-1:0] meas_width, meas_height;

  int         checks = 0;
  int         fails  = 0;
  logic [7:0] expQ[$];
  int         doneCnt = 0;
  int         lineErrCnt = 0;
  logic       lastFrameErr = 1'b0;
  logic [CNT_W-1:0] lastMeasH = '0;
  logic [CNT_W-1:0] measWAtErr = '0;
  logic       prevPosVs = 1'b0;
  logic       prevPosHr = 1'b0;
  logic       sawMode3 = 1'b0;
  logic       mfConst = 1'b0;
  logic       pendAtCfg = 1'b0;
  logic [1:0] modeAtCfg = 2'd0;
  logic [7:0] monExp;

  vip_filter_frame_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(CNT_W), .DEF_MODE(DEF_MODE)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode),
    .pe_frame_vsync(pe_frame_vsync), .pe_frame_href(pe_frame_href),
    .pe_frame_clken(pe_frame_clken), .pe_img_Y(pe_img_Y),
    .mf_frame_vsync(mf_frame_vsync), .mf_frame_href(mf_frame_href),
    .mf_frame_clken(mf_frame_clken), .mf_img_Y(mf_img_Y),
    .pos_frame_vsync(pos_frame_vsync), .pos_frame_href(pos_frame_href),
    .pos_frame_clken(pos_frame_clken), .pos_img_Y(pos_img_Y),
    .active_mode(active_mode), .cfg_pending(cfg_pending), .frame_done(frame_done),
    .line_err(line_err), .frame_err(frame_err),
    .meas_width(meas_width), .meas_height(meas_height)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected test sequence to finish");
    $fatal(1, "[TB] watchdog");
  end

  // Output monitor: pops the scoreboard on every valid output pixel and tracks status pulses.
  always @(negedge clk) begin
    if (pos_frame_href && pos_frame_clken) begin
      checks++;
      if (expQ.size() == 0) begin
        fails++;
        $display("[TB] FAIL pixel_extra: got Y=%h, expected no pixel", pos_img_Y);
      end else begin
        monExp = expQ.pop_front();
        if (pos_img_Y !== monExp) begin
          fails++;
          $display("[TB] FAIL pixel: got Y=%h, expected %h", pos_img_Y, monExp);
        end
      end
    end else if (!pos_frame_href) begin
      checks++;
      if (pos_img_Y !== 8'h00) begin
        fails++;
        $display("[TB] FAIL y_blank: got Y=%h while href low, expected 00", pos_img_Y);
      end
    end
    if (frame_done) begin
      doneCnt++;
      lastFrameErr = frame_err;
      lastMeasH    = meas_height;
      checks++;
      if (!(prevPosVs && !pos_frame_vsync)) begin
        fails++;
        $display("[TB] FAIL done_align: frame_done with vsync prev=%b now=%b, expected 1/0", prevPosVs, pos_frame_vsync);
      end
    end
    if (line_err) begin
      lineErrCnt++;
      measWAtErr = meas_width;
      checks++;
      if (!(prevPosHr && !pos_frame_href)) begin
        fails++;
        $display("[TB] FAIL lerr_align: line_err with href prev=%b now=%b, expected 1/0", prevPosHr, pos_frame_href);
      end
    end
    if (active_mode == 2'd3) sawMode3 = 1'b1;
    prevPosVs = pos_frame_vsync;
    prevPosHr = pos_frame_href;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic vs, input logic hr, input logic ck, input logic peOn,
                               input logic [7:0] pY, input logic [7:0] mY);
    mf_frame_vsync = vs;
    mf_frame_href  = hr;
    mf_frame_clken = ck;
    mf_img_Y       = mY;
    pe_frame_vsync = peOn ? vs : 1'b0;
    pe_frame_href  = peOn ? hr : 1'b0;
    pe_frame_clken = peOn ? ck : 1'b0;
    pe_img_Y       = peOn ? pY : 8'h00;
  endtask

  task automatic pulseCfg(input logic [1:0] m);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    cfg_valid = 1'b1;
    cfg_mode  = m;
    tick();
    cfg_valid = 1'b0;
    tick();
  endtask

  // Drives one frame on both paths (pe optionally idle) and queues the expected output pixels.
  task automatic drive_frame(input int nLines, input int shortRow, input logic [1:0] expMode,
                             input logic peOn, input int cfgRow1, input logic [1:0] cfgMode1,
                             input int cfgRow2, input logic [1:0] cfgMode2, input int abortRow);
    logic [7:0] pY, mY, e;
    int len;
    for (int i = 0; i < 4; i++) begin applyStimulus(1'b0, 1'b0, 1'b0, peOn, 8'h00, 8'h00); tick(); end
    for (int i = 0; i < 2; i++) begin applyStimulus(1'b1, 1'b0, 1'b0, peOn, 8'h00, 8'h00); tick(); end
    for (int r = 0; r < nLines; r++) begin
      len = (r == shortRow) ? IMG_W - 1 : IMG_W;
      for (int c = 0; c < len; c++) begin
        if (r == abortRow && c == 3) begin
          applyStimulus(1'b1, 1'b1, 1'b1, peOn, 8'h11, 8'h22);
          rst = 1'b1;
          tick();
          rst = 1'b0;
          return;
        end
        if (c == 3) begin
          applyStimulus(1'b1, 1'b1, 1'b0, peOn, 8'($urandom), 8'($urandom));
          tick();
        end
        pY = 8'($urandom);
        mY = mfConst ? 8'h80 : 8'($urandom);
        case (expMode)
          2'd0:    e = peOn ? pY : 8'h00;
          2'd1:    e = mY;
          2'd2:    e = (c == 0 || c == IMG_W - 1 || r == 0 || r == IMG_H - 1) ? 8'h00 : mY;
          default: e = 8'h00;
        endcase
        expQ.push_back(e);
        applyStimulus(1'b1, 1'b1, 1'b1, peOn, pY, mY);
        tick();
      end
      for (int b = 0; b < 3; b++) begin
        applyStimulus(1'b1, 1'b0, 1'b0, peOn, 8'h00, 8'h00);
        if (b == 0 && r == cfgRow1) begin cfg_valid = 1'b1; cfg_mode = cfgMode1; end
        else if (b == 0 && r == cfgRow2) begin cfg_valid = 1'b1; cfg_mode = cfgMode2; end
        tick();
        if (cfg_valid) begin
          cfg_valid = 1'b0;
          pendAtCfg = cfg_pending;
          modeAtCfg = active_mode;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin applyStimulus(1'b1, 1'b0, 1'b0, peOn, 8'h00, 8'h00); tick(); end
    for (int i = 0; i < 3; i++) begin applyStimulus(1'b0, 1'b0, 1'b0, peOn, 8'h00, 8'h00); tick(); end
  endtask

  task automatic test_reset();
    checks++;
    if ({pos_frame_vsync, pos_frame_href, pos_frame_clken, pos_img_Y} !== 11'h0) begin
      fails++; $display("[TB] FAIL rst_pos: got %h, expected 0", {pos_frame_vsync, pos_frame_href, pos_frame_clken, pos_img_Y});
    end
    checks++;
    if (active_mode !== DEF_MODE) begin
      fails++; $display("[TB] FAIL rst_mode: got %0d, expected %0d", active_mode, DEF_MODE);
    end
    checks++;
    if ({cfg_pending, frame_done, line_err, frame_err} !== 4'h0) begin
      fails++; $display("[TB] FAIL rst_flags: got %b, expected 0000", {cfg_pending, frame_done, line_err, frame_err});
    end
    checks++;
    if ({meas_width, meas_height} !== '0) begin
      fails++; $display("[TB] FAIL rst_meas: got w=%0d h=%0d, expected 0/0", meas_width, meas_height);
    end
  endtask

  task automatic test_median();
    int d0 = doneCnt;
    int l0 = lineErrCnt;
    drive_frame(IMG_H, -1, 2'd1, 1'b0, -1, 2'd0, -1, 2'd0, -1);
    checks++;
    if (doneCnt !== d0 + 1) begin fails++; $display("[TB] FAIL med_done: got %0d pulses, expected 1", doneCnt - d0); end
    checks++;
    if (lastFrameErr !== 1'b0) begin fails++; $display("[TB] FAIL med_ferr: got %b, expected 0", lastFrameErr); end
    checks++;
    if (lastMeasH !== 12'd4) begin fails++; $display("[TB] FAIL med_height: got %0d, expected 4", lastMeasH); end
    checks++;
    if (meas_width !== 12'd8) begin fails++; $display("[TB] FAIL med_width: got %0d, expected 8", meas_width); end
    checks++;
    if (lineErrCnt !== l0) begin fails++; $display("[TB] FAIL med_lerr: got %0d pulses, expected 0", lineErrCnt - l0); end
    checks++;
    if (expQ.size() !== 0) begin fails++; $display("[TB] FAIL med_missing: got %0d pixels left, expected 0", expQ.size()); end
  endtask

  task automatic test_border();
    int d0 = doneCnt;
    pulseCfg(2'd2);
    checks++;
    if (active_mode !== 2'd2 || cfg_pending !== 1'b0) begin
      fails++; $display("[TB] FAIL bord_commit: got mode=%0d pend=%b, expected 2/0", active_mode, cfg_pending);
    end
    mfConst = 1'b1;
    drive_frame(IMG_H, -1, 2'd2, 1'b1, -1, 2'd0, -1, 2'd0, -1);
    mfConst = 1'b0;
    checks++;
    if (expQ.size() !== 0 || doneCnt !== d0 + 1) begin
      fails++; $display("[TB] FAIL bord_frame: got left=%0d done=%0d, expected 0/1", expQ.size(), doneCnt - d0);
    end
  endtask

  task automatic test_midframe_switch();
    drive_frame(IMG_H, -1, 2'd2, 1'b1, 1, 2'd0, -1, 2'd0, -1);
    checks++;
    if (pendAtCfg !== 1'b1 || modeAtCfg !== 2'd2) begin
      fails++; $display("[TB] FAIL mid_pending: got pend=%b mode=%0d, expected 1/2", pendAtCfg, modeAtCfg);
    end
    checks++;
    if (active_mode !== 2'd0 || cfg_pending !== 1'b0) begin
      fails++; $display("[TB] FAIL mid_commit: got mode=%0d pend=%b, expected 0/0", active_mode, cfg_pending);
    end
    drive_frame(IMG_H, -1, 2'd0, 1'b1, -1, 2'd0, -1, 2'd0, -1);
    checks++;
    if (expQ.size() !== 0) begin fails++; $display("[TB] FAIL mid_missing: got %0d left, expected 0", expQ.size()); end
  endtask

  task automatic test_back_to_back();
    pulseCfg(2'd1);
    sawMode3 = 1'b0;
    drive_frame(IMG_H, -1, 2'd1, 1'b1, 0, 2'd3, 2, 2'd0, -1);
    checks++;
    if (active_mode !== 2'd0 || cfg_pending !== 1'b0) begin
      fails++; $display("[TB] FAIL b2b_commit: got mode=%0d pend=%b, expected 0/0", active_mode, cfg_pending);
    end
    drive_frame(IMG_H, -1, 2'd0, 1'b1, -1, 2'd0, -1, 2'd0, -1);
    checks++;
    if (sawMode3 !== 1'b0) begin fails++; $display("[TB] FAIL b2b_mode3: got mode 3 applied=%b, expected 0", sawMode3); end
  endtask

  task automatic test_short_line();
    int d0 = doneCnt;
    int l0 = lineErrCnt;
    drive_frame(IMG_H, 1, 2'd0, 1'b1, -1, 2'd0, -1, 2'd0, -1);
    checks++;
    if (lineErrCnt !== l0 + 1) begin fails++; $display("[TB] FAIL short_lerr: got %0d pulses, expected 1", lineErrCnt - l0); end
    checks++;
    if (measWAtErr !== 12'd7) begin fails++; $display("[TB] FAIL short_width: got %0d, expected 7", measWAtErr); end
    checks++;
    if (lastFrameErr !== 1'b1 || doneCnt !== d0 + 1) begin
      fails++; $display("[TB] FAIL short_ferr: got ferr=%b done=%0d, expected 1/1", lastFrameErr, doneCnt - d0);
    end
    checks++;
    if (lastMeasH !== 12'd4 || meas_width !== 12'd8) begin
      fails++; $display("[TB] FAIL short_meas: got h=%0d w=%0d, expected 4/8", lastMeasH, meas_width);
    end
  endtask

  task automatic test_reset_midframe();
    int d0 = doneCnt;
    drive_frame(IMG_H, -1, 2'd0, 1'b1, -1, 2'd0, -1, 2'd0, 2);
    checks++;
    if ({pos_frame_vsync, pos_frame_href, pos_frame_clken, pos_img_Y} !== 11'h0) begin
      fails++; $display("[TB] FAIL mrst_pos: got %h, expected 0", {pos_frame_vsync, pos_frame_href, pos_frame_clken, pos_img_Y});
    end
    checks++;
    if (active_mode !== DEF_MODE || {cfg_pending, frame_done, line_err} !== 3'b000) begin
      fails++; $display("[TB] FAIL mrst_state: got mode=%0d flags=%b, expected %0d/000", active_mode, {cfg_pending, frame_done, line_err}, DEF_MODE);
    end
    checks++;
    if (expQ.size() !== 0) begin fails++; $display("[TB] FAIL mrst_queue: got %0d left, expected 0", expQ.size()); end
    for (int i = 0; i < 4; i++) begin applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 8'h44); tick(); end
    for (int i = 0; i < 3; i++) begin applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00); tick(); end
    for (int i = 0; i < 4; i++) begin applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00); tick(); end
    checks++;
    if (doneCnt !== d0) begin fails++; $display("[TB] FAIL mrst_nodone: got %0d pulses, expected 0", doneCnt - d0); end
    drive_frame(IMG_H, -1, DEF_MODE, 1'b1, -1, 2'd0, -1, 2'd0, -1);
    checks++;
    if (doneCnt !== d0 + 1 || lastFrameErr !== 1'b0 || lastMeasH !== 12'd4) begin
      fails++; $display("[TB] FAIL mrst_resume: got done=%0d ferr=%b h=%0d, expected 1/0/4", doneCnt - d0, lastFrameErr, lastMeasH);
    end
    checks++;
    if (expQ.size() !== 0) begin fails++; $display("[TB] FAIL mrst_missing: got %0d left, expected 0", expQ.size()); end
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_mode  = 2'd0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_reset();
    test_median();
    test_border();
    test_midframe_switch();
    test_back_to_back();
    test_short_line();
    test_reset_midframe();
    for (int i = 0; i < 3; i++) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
